// File: rtl/brief_pkg.sv
// Shared types for the BRIEF descriptor generator: FSM states, pixel type and
// the deterministic sampling-pair table with its pixel-index helper.
package brief_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FETCH,
        S_CAPTURE,
        S_COMPARE,
        S_OUTPUT
    } state_t;

    typedef logic [7:0] pixel_t;

    // One sampling pair: offsets of A and B from the patch centre (x = column, y = row).
    typedef struct packed {
        logic signed [7:0] ax;
        logic signed [7:0] ay;
        logic signed [7:0] bx;
        logic signed [7:0] by;
    } pair_t;

    // Pair table entry i, spread over [-patch/2, patch/2] with co-prime strides.
    function automatic pair_t pair_at(input int i, input int patch);
        int    half;
        int    span;
        pair_t p;
        half = patch / 2;
        span = 2 * half + 1;
        p.ax = 8'((i * 37 + 11) % span - half);
        p.ay = 8'((i * 53 + 5) % span - half);
        p.bx = 8'((i * 71 + 23) % span - half);
        p.by = 8'((i * 97 + 3) % span - half);
        return p;
    endfunction

    // Row-major pixel index of a centre-relative offset; row 0 is the top row.
    function automatic int pix_index(input logic signed [7:0] dx, input logic signed [7:0] dy,
                                     input int patch);
        return (patch / 2 + int'(dy)) * patch + patch / 2 + int'(dx);
    endfunction

endpackage

// File: rtl/brief_cmp_unit.sv
// CMP_PER_CYC parallel pixel muxes and unsigned comparators; lane j resolves
// descriptor bit k*CMP_PER_CYC+j (1 when pixel A < pixel B).
module brief_cmp_unit
    import brief_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int PATCH       = 31,
    parameter int PNUM        = 256,
    parameter int CMP_PER_CYC = 8,
    parameter int KW          = 5
) (
    input  logic [PATCH*PATCH*BITS-1:0] patch,
    input  logic [KW-1:0]               k,
    input  pair_t                       pairs [PNUM],
    output logic [CMP_PER_CYC-1:0]      cmp_bits
);
    localparam int NPIX = PATCH * PATCH;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = (PNUM > 1) ? $clog2(PNUM) : 1;

    logic [BITS-1:0] pix [NPIX];

    for (genvar g = 0; g < NPIX; g++) begin : g_pix
        assign pix[g] = patch[g*BITS +: BITS];
    end

    always_comb begin
        cmp_bits = '0;
        for (int j = 0; j < CMP_PER_CYC; j++) begin
            cmp_bits[j] =
                pix[AW'(pix_index(pairs[PW'(int'(k) * CMP_PER_CYC + j)].ax,
                                  pairs[PW'(int'(k) * CMP_PER_CYC + j)].ay, PATCH))] <
                pix[AW'(pix_index(pairs[PW'(int'(k) * CMP_PER_CYC + j)].bx,
                                  pairs[PW'(int'(k) * CMP_PER_CYC + j)].by, PATCH))];
        end
    end

endmodule

// File: rtl/brief_desc_gen.sv
// BRIEF descriptor generator: border check, one-shot patch fetch, multi-cycle
// pair comparison and a held descriptor output. Optional BRIEF_STATS_EN adds counters.
module brief_desc_gen
    import brief_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int PATCH       = 31,
    parameter int PNUM        = 256,
    parameter int CMP_PER_CYC = 8,
    parameter int IMG_W       = 1280,
    parameter int IMG_H       = 720,
    parameter int BORDER      = 15,
    parameter int ADDRLEN     = 21
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kp_valid,
    output logic                          kp_ready,
    input  logic [10:0]                   kp_x,
    input  logic [10:0]                   kp_y,
    output logic                          patch_req,
    output logic [ADDRLEN-1:0]            patch_addr,
    input  logic [PATCH*PATCH*BITS-1:0]   patch_data,
    output logic                          desc_valid,
    input  logic                          desc_ready,
    output logic [PNUM-1:0]               desc,
    output logic [10:0]                   desc_x,
    output logic [10:0]                   desc_y,
    output logic                          rejected,
    output state_t                        dbg_state
`ifdef BRIEF_STATS_EN
    ,
    output logic [15:0]                   n_accepted,
    output logic [15:0]                   n_rejected
`endif
);
    localparam int NCYC  = PNUM / CMP_PER_CYC;
    localparam int KW    = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int PBITS = PATCH * PATCH * BITS;

    state_t                 state_q, state_d;
    logic [10:0]            x_q, x_d, y_q, y_d;
    logic [ADDRLEN-1:0]     addr_q, addr_d;
    logic [PBITS-1:0]       patch_q, patch_d;
    logic [KW-1:0]          k_q, k_d;
    logic [PNUM-1:0]        desc_q, desc_d;
    logic [CMP_PER_CYC-1:0] cmp_bits;
    logic                   in_bounds;
    pair_t                  pair_tab [PNUM];

    for (genvar i = 0; i < PNUM; i++) begin : g_pair
        assign pair_tab[i] = pair_at(i, PATCH);
    end

    brief_cmp_unit #(
        .BITS(BITS), .PATCH(PATCH), .PNUM(PNUM), .CMP_PER_CYC(CMP_PER_CYC), .KW(KW)
    ) u_cmp (
        .patch(patch_q), .k(k_q), .pairs(pair_tab), .cmp_bits(cmp_bits)
    );

    // All four bounds are strict: a keypoint sitting exactly on the border is rejected.
    assign in_bounds = (int'(x_q) > BORDER) && (int'(y_q) > BORDER) &&
                       (int'(x_q) < IMG_W - BORDER) && (int'(y_q) < IMG_H - BORDER);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        patch_d = patch_q;
        k_d     = k_q;
        desc_d  = desc_q;
        case (state_q)
            S_IDLE: begin
                if (kp_valid) begin
                    x_d     = kp_x;
                    y_d     = kp_y;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (in_bounds) begin
                    addr_d  = ADDRLEN'(y_q) * ADDRLEN'(IMG_W) + ADDRLEN'(x_q);
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: state_d = S_CAPTURE;
            S_CAPTURE: begin
                patch_d = patch_data;
                k_d     = '0;
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                for (int k = 0; k < NCYC; k++) begin
                    if (k_q == KW'(k)) desc_d[k*CMP_PER_CYC +: CMP_PER_CYC] = cmp_bits;
                end
                if (k_q == KW'(NCYC - 1)) state_d = S_OUTPUT;
                else                      k_d     = k_q + 1'b1;
            end
            S_OUTPUT: begin
                if (desc_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            patch_q <= '0;
            k_q     <= '0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            patch_q <= patch_d;
            k_q     <= k_d;
            desc_q  <= desc_d;
        end
    end

    // State decodes are masked by rst so every control output reads 0 while reset is held.
    assign kp_ready   = (state_q == S_IDLE) && !rst;
    assign patch_req  = (state_q == S_FETCH) && !rst;
    assign rejected   = (state_q == S_CHECK) && !in_bounds && !rst;
    assign desc_valid = (state_q == S_OUTPUT) && !rst;
    assign patch_addr = addr_q;
    assign desc       = desc_q;
    assign desc_x     = x_q;
    assign desc_y     = y_q;
    assign dbg_state  = state_q;

`ifdef BRIEF_STATS_EN
    logic [15:0] n_acc_q, n_acc_d, n_rej_q, n_rej_d;

    always_comb begin
        n_acc_d = n_acc_q;
        n_rej_d = n_rej_q;
        if (state_q == S_CHECK) begin
            if (in_bounds && n_acc_q != 16'hFFFF)       n_acc_d = n_acc_q + 16'd1;
            else if (!in_bounds && n_rej_q != 16'hFFFF) n_rej_d = n_rej_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_acc_q <= '0;
            n_rej_q <= '0;
        end else begin
            n_acc_q <= n_acc_d;
            n_rej_q <= n_rej_d;
        end
    end

    assign n_accepted = n_acc_q;
    assign n_rejected = n_rej_q;
`endif

endmodule

// File: tb/tb_brief_desc_gen.sv
// Self-checking bench for brief_desc_gen at PATCH=15: directed keypoints, a patch
// buffer responder, a descriptor model and a per-cycle output scoreboard.
module tb_brief_desc_gen;
    import brief_pkg::*;

    localparam int BITS    = 8;
    localparam int PATCH   = 15;
    localparam int PNUM    = 256;
    localparam int CPC     = 8;
    localparam int PBITS   = PATCH * PATCH * BITS;
    localparam int ADDRLEN = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               kp_valid, kp_ready;
    logic [10:0]        kp_x, kp_y;
    logic               patch_req;
    logic [ADDRLEN-1:0] patch_addr;
    logic [PBITS-1:0]   patch_data;
    logic               desc_valid, desc_ready;
    logic [PNUM-1:0]    desc;
    logic [10:0]        desc_x, desc_y;
    logic               rejected;
    state_t             dbg_state;
`ifdef BRIEF_STATS_EN
    logic [15:0]        n_accepted, n_rejected;
`endif

    brief_desc_gen #(
        .BITS(BITS), .PATCH(PATCH), .PNUM(PNUM), .CMP_PER_CYC(CPC),
        .IMG_W(1280), .IMG_H(720), .BORDER(15), .ADDRLEN(ADDRLEN)
    ) dut (
        .clk(clk), .rst(rst),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
        .patch_req(patch_req), .patch_addr(patch_addr), .patch_data(patch_data),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc(desc),
        .desc_x(desc_x), .desc_y(desc_y), .rejected(rejected), .dbg_state(dbg_state)
`ifdef BRIEF_STATS_EN
        ,
        .n_accepted(n_accepted), .n_rejected(n_rejected)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard state ----------------
    int                          compared   = 0;
    int                          mismatched = 0;
    logic [PNUM+21:0]            exp_q[$];          // {y, x, desc}
    logic [PBITS-1:0]            cur_vec;
    int                          pix [PATCH][PATCH];
    int                          req_cnt = 0, rej_cnt = 0, hs_cnt = 0;
    logic [ADDRLEN-1:0]          last_addr;
    logic [PNUM-1:0]             last_desc;
    logic                        req_s;

    task automatic chk(input string name, input logic [PNUM-1:0] act, input logic [PNUM-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Descriptor straight from the pair rule on a 2-D pixel array.
    function automatic logic [PNUM-1:0] model_desc();
        logic [PNUM-1:0] d;
        pair_t           p;
        int              h, a, b;
        d = '0;
        h = PATCH / 2;
        for (int i = 0; i < PNUM; i++) begin
            p = pair_at(i, PATCH);
            a = pix[h + int'(p.ay)][h + int'(p.ax)];
            b = pix[h + int'(p.by)][h + int'(p.bx)];
            d[i] = (a < b);
        end
        return d;
    endfunction

    task automatic load_patch(input int kind);
        for (int r = 0; r < PATCH; r++)
            for (int c = 0; c < PATCH; c++) begin
                case (kind)
                    0:       pix[r][c] = r * PATCH + c;
                    1:       pix[r][c] = 'h80;
                    default: pix[r][c] = $urandom_range(0, 255);
                endcase
                cur_vec[(r*PATCH+c)*BITS +: BITS] = BITS'(pix[r][c]);
            end
    endtask

    // Patch buffer: data answers one cycle after a request, garbage otherwise.
    initial begin
        patch_data = '0;
        forever begin
            @(negedge clk);
            req_s = patch_req;
            @(posedge clk);
            #1;
            patch_data = req_s ? cur_vec : ~cur_vec;
        end
    end

    // Compare process: every cycle desc_valid is up, outputs must match the queue head.
    always @(negedge clk) begin
        logic [PNUM+21:0] e;
        if (!rst) begin
            if (patch_req) begin
                req_cnt++;
                last_addr = patch_addr;
            end
            if (rejected) rej_cnt++;
            if (desc_valid) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_desc_valid: got desc_valid=1 expected 0");
                end else begin
                    e = exp_q[0];
                    chk("desc", desc, e[PNUM-1:0]);
                    chk("desc_x", PNUM'(desc_x), PNUM'(e[PNUM+10:PNUM]));
                    chk("desc_y", PNUM'(desc_y), PNUM'(e[PNUM+21:PNUM+11]));
                    if (desc_ready) begin
                        last_desc = desc;
                        hs_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_kp(input int x, input int y, input bit push, input logic [PNUM-1:0] e);
        bit ok;
        kp_x     = 11'(x);
        kp_y     = 11'(y);
        kp_valid = 1'b1;
        if (push) exp_q.push_back({11'(y), 11'(x), e});
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (kp_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        #1;
        kp_valid = 1'b0;
        chk("kp_accept_timeout", PNUM'(ok), PNUM'(1));
    endtask

    task automatic wait_hs(input int target);
        for (int n = 0; n < 400 && hs_cnt < target; n++) @(negedge clk);
        chk("handshake_timeout", PNUM'(hs_cnt >= target), PNUM'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [PNUM-1:0] e, held;
        int              n, r0, q0, h0;

        rst = 1'b1; kp_valid = 1'b0; kp_x = '0; kp_y = '0; desc_ready = 1'b1;
        load_patch(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_kp_ready", PNUM'(kp_ready), 0);
        chk("rst_patch_req", PNUM'(patch_req), 0);
        chk("rst_desc_valid", PNUM'(desc_valid), 0);
        chk("rst_rejected", PNUM'(rejected), 0);
        chk("rst_desc", desc, 0);
        chk("rst_desc_x", PNUM'(desc_x), 0);
        chk("rst_desc_y", PNUM'(desc_y), 0);
        chk("rst_patch_addr", PNUM'(patch_addr), 0);
        chk("rst_state", PNUM'(dbg_state), PNUM'(S_IDLE));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("kp_ready_after_rst", PNUM'(kp_ready), 1);
        idle_cycles(1);

        // Ramp patch at (100,100): address, latency and hand-pinned low bits.
        load_patch(0);
        e = model_desc();
        chk("model_ramp_lsbs", PNUM'(e[5:0]), PNUM'(6'b100000));
        send_kp(100, 100, 1'b1, e);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (desc_valid) break;
        end
        chk("latency", PNUM'(n), PNUM'(36));
        wait_hs(1);
        chk("patch_addr_100_100", PNUM'(last_addr), PNUM'(128100));
        chk("ramp_desc_lsbs", PNUM'(last_desc[5:0]), PNUM'(6'b100000));
        chk("req_count_ramp", PNUM'(req_cnt), 1);

        // Border rejects: no read, no descriptor, one pulse each.
        r0 = rej_cnt; q0 = req_cnt; h0 = hs_cnt;
        send_kp(15, 300, 1'b0, '0);
        idle_cycles(3);
        send_kp(1265, 300, 1'b0, '0);
        idle_cycles(3);
        chk("reject_pulses", PNUM'(rej_cnt - r0), 2);
        chk("reject_no_req", PNUM'(req_cnt - q0), 0);
        chk("reject_no_desc", PNUM'(hs_cnt - h0), 0);

        // Just-inside corners are accepted.
        load_patch(2);
        send_kp(16, 16, 1'b1, model_desc());
        wait_hs(h0 + 1);
        chk("patch_addr_16_16", PNUM'(last_addr), PNUM'(16 * 1280 + 16));
        load_patch(2);
        send_kp(1264, 704, 1'b1, model_desc());
        wait_hs(h0 + 2);
        chk("patch_addr_1264_704", PNUM'(last_addr), PNUM'(902384));
        chk("accept_req_count", PNUM'(req_cnt - q0), 2);

        // Flat patch gives an all-zero descriptor.
        load_patch(1);
        send_kp(200, 150, 1'b1, model_desc());
        wait_hs(h0 + 3);
        chk("flat_desc_zero", last_desc, 0);

        // Back-pressure: desc held for 10 cycles, no new keypoint accepted.
        load_patch(2);
        desc_ready = 1'b0;
        send_kp(640, 360, 1'b1, model_desc());
        for (int i = 0; i < 100 && !desc_valid; i++) @(negedge clk);
        held = desc;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_desc_valid", PNUM'(desc_valid), 1);
            chk("stall_kp_ready", PNUM'(kp_ready), 0);
            chk("stall_desc_stable", desc, held);
        end
        @(posedge clk); #1 desc_ready = 1'b1;
        wait_hs(h0 + 4);

        // Reset in the 5th compare cycle discards the descriptor.
        load_patch(0);
        send_kp(300, 200, 1'b0, '0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("in_compare_before_rst", PNUM'(dbg_state), PNUM'(S_COMPARE));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_state", PNUM'(dbg_state), PNUM'(S_IDLE));
        chk("rst_mid_desc_valid", PNUM'(desc_valid), 0);
        chk("rst_mid_desc", desc, 0);
        idle_cycles(1);
        load_patch(2);
        send_kp(300, 200, 1'b1, model_desc());
        wait_hs(h0 + 5);

`ifdef BRIEF_STATS_EN
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(1);
        load_patch(1);
        for (int i = 0; i < 3; i++) begin
            send_kp(50 + i, 60, 1'b1, model_desc());
            wait_hs(h0 + 6 + i);
        end
        send_kp(5, 60, 1'b0, '0);
        idle_cycles(3);
        send_kp(50, 710, 1'b0, '0);
        idle_cycles(3);
        chk("n_accepted", PNUM'(n_accepted), 3);
        chk("n_rejected", PNUM'(n_rejected), 2);
        dut.n_rej_q = 16'hFFFD;
        idle_cycles(1);
        for (int i = 0; i < 4; i++) begin
            send_kp(0, 0, 1'b0, '0);
            idle_cycles(3);
        end
        chk("n_rejected_sat", PNUM'(n_rejected), PNUM'(16'hFFFF));
`endif

        idle_cycles(5);
        chk("exp_queue_drained", PNUM'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
